fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
- REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters (2..8).
- REQ-002 SHALL have parameter DATA_WIDTH, default 16: beat width, equal to the FIFO write width.
- REQ-003 SHALL have parameter BURST_LEN, default 16: beats per granted burst (2..WR_DEPTH).
- REQ-004 SHALL have parameter SPACE_WIDTH, default 7: width of the FIFO write-space input, i.e. clog2(WR_DEPTH)+1.
- REQ-005 SHALL have port clock, input, 1: single clock; all logic rising-edge.
- REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
- REQ-007 SHALL have port enable, input, 1: 1 = new grants allowed; 0 = no new grants, current burst completes.
- REQ-008 SHALL have port req, input, NUM_REQ: per-requester burst request, level, held until granted.
- REQ-009 SHALL have port src_valid, input, NUM_REQ: per-requester beat valid.
- REQ-010 SHALL have port src_data, input, NUM_REQ*DATA_WIDTH: requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- REQ-011 SHALL have port src_ready, output, NUM_REQ: beat accepted when src_valid[i] & src_ready[i].
- REQ-012 SHALL have port grant, output, NUM_REQ: one-hot current owner; all-zero when no burst is active.
- REQ-013 SHALL have port fifo_full, input, 1: FIFO full flag, write domain.
- REQ-014 SHALL have port fifo_wr_data_space, input, SPACE_WIDTH: free FIFO entries in write words.
- REQ-015 SHALL have port fifo_wr_en, output, 1: FIFO write enable.
- REQ-016 SHALL have port fifo_din, output, DATA_WIDTH: FIFO write data.
- REQ-017 SHALL have port busy, output, 1: high while the state is BURST or REST.
- REQ-018 SHALL have port burst_done, output, 1: one-cycle pulse on the cycle after the last beat of a burst is written.

Function
- REQ-019 SHALL implement states IDLE, BURST and REST.
- REQ-020 IDLE SHALL go to BURST when enable=1, req!=0 and fifo_wr_data_space>=BURST_LEN (unsigned compare); otherwise it SHALL stay in IDLE.
- REQ-021 On the IDLE->BURST transition, grant SHALL register the round-robin winner: the first set req bit searching upward from ptr+1 modulo NUM_REQ.
- REQ-022 Winner selection SHALL be decided in the same cycle the condition holds; grant SHALL be visible the next cycle, giving 1-cycle req->grant latency.
- REQ-023 In BURST, src_ready[g] SHALL be ~fifo_full for the granted g, and src_ready SHALL be 0 for all other requesters.
- REQ-024 In BURST, fifo_wr_en SHALL be src_valid[g] & ~fifo_full (combinational) and fifo_din SHALL be src_data of g (combinational mux).
- REQ-025 Outside BURST, fifo_wr_en SHALL be 0, src_ready SHALL be all-zero and fifo_din SHALL be 0.
- REQ-026 The beat counter SHALL be clog2(BURST_LEN)+1 bits wide, SHALL clear on entry to BURST and SHALL increment on each fifo_wr_en.
- REQ-027 When fifo_wr_en=1 with the count at BURST_LEN-1, the block SHALL go to REST, set ptr<=g, clear grant and assert burst_done in the next cycle.
- REQ-028 REST SHALL last exactly 1 cycle, then go to IDLE, so that fifo_wr_data_space settles before the next admission.
- REQ-029 src_valid low mid-burst SHALL stall the burst without timeout; the grant SHALL be held.
- REQ-030 fifo_full mid-burst SHALL stall the burst; no write SHALL occur while fifo_full=1 (no overflow generated).
- REQ-031 A req drop mid-burst SHALL be ignored; req SHALL be sampled only in IDLE.
- REQ-032 enable falling mid-burst SHALL NOT abort the burst; the block SHALL return to IDLE and hold there.
- REQ-033 With only one requester active, that requester SHALL be re-granted after each REST.
- REQ-034 Every burst SHALL write exactly BURST_LEN beats, with no beat duplicated or dropped.

Reset
- REQ-035 While reset=1 at a clock edge: state SHALL be IDLE, grant=0, ptr=NUM_REQ-1 (requester 0 wins first), beat counter=0, busy=0, burst_done=0; src_ready, fifo_wr_en and fifo_din SHALL be 0.
- REQ-036 Reset asserted mid-burst SHALL take priority: the burst SHALL be abandoned, with no fifo_wr_en from the cycle after the reset edge.

Verification
- REQ-037 Rotation: req=4'b1111, all valid, space=64 -> grants 0001,0010,0100,1000,0001, each 16 writes, burst_done after each, 1 idle REST cycle between bursts.
- REQ-038 Space gate: req=4'b0100, space=15 -> no grant; space raised to 16 -> grant=0100 the next cycle.
- REQ-039 Backpressure: fifo_full=1 for 5 cycles at beat 7 -> fifo_wr_en=0 for those cycles, 16 beats total, data order preserved.
- REQ-040 Valid gap: src_valid[1] low 3 cycles mid-burst -> grant stays 0010, count resumes, burst_done after beat 16.
- REQ-041 Reset mid-burst at beat 9 -> grant=0 and fifo_wr_en=0 next cycle; after release, requester 0 wins first.
- REQ-042 Enable: enable=0 at beat 4 -> burst completes (16 writes), then no grant until enable=1.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter: grants one requester at a time a fixed-length
// burst of FIFO writes, gated on enough free FIFO space at admission.
module fifo_wr_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 16,
  parameter int BURST_LEN   = 16,
  parameter int SPACE_WIDTH = 7
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            enable,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ-1:0]              src_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   src_data,
  output logic [NUM_REQ-1:0]              src_ready,
  output logic [NUM_REQ-1:0]              grant,
  input  logic                            fifo_full,
  input  logic [SPACE_WIDTH-1:0]          fifo_wr_data_space,
  output logic                            fifo_wr_en,
  output logic [DATA_WIDTH-1:0]           fifo_din,
  output logic                            busy,
  output logic                            burst_done
);

  localparam int CNT_W = $clog2(BURST_LEN) + 1;
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [SPACE_WIDTH-1:0] BL_SPACE = SPACE_WIDTH'(BURST_LEN);
  localparam logic [CNT_W-1:0]       LAST_CNT = CNT_W'(BURST_LEN - 1);
  localparam logic [PTR_W-1:0]       PTR_RST  = PTR_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, BURST, REST} state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;

  logic [NUM_REQ-1:0] win_oh;
  logic [PTR_W-1:0]   g_idx;
  logic               g_valid;
  logic [DATA_WIDTH-1:0] g_data;

  // Round-robin search upward from ptr+1, wrapping modulo NUM_REQ.
  always_comb begin
    int idx;
    logic found;
    idx    = 0;
    found  = 1'b0;
    win_oh = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        win_oh[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  // Decode the one-hot owner into an index and select its beat.
  always_comb begin
    g_idx   = '0;
    g_valid = 1'b0;
    g_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        g_idx   = PTR_W'(i);
        g_valid = src_valid[i];
        g_data  = src_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    src_ready  = '0;
    fifo_wr_en = 1'b0;
    fifo_din   = '0;
    if (state_q == BURST) begin
      src_ready  = fifo_full ? '0 : grant_q;
      fifo_wr_en = g_valid & ~fifo_full;
      fifo_din   = g_data;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && (req != '0) && (fifo_wr_data_space >= BL_SPACE)) begin
          state_d = BURST;
          grant_d = win_oh;
          cnt_d   = '0;
        end
      end
      BURST: begin
        if (fifo_wr_en) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            state_d = REST;
            ptr_d   = g_idx;
            grant_d = '0;
            done_d  = 1'b1;
          end
        end
      end
      // One cycle for the FIFO's space count to reflect the burst.
      REST:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= PTR_RST;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign grant      = grant_q;
  assign busy       = (state_q == BURST) || (state_q == REST);
  assign burst_done = done_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed scenarios followed by random traffic, every cycle compared against
// a requester/burst-level reference model.
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int BL = 16;
  localparam int SW = 7;

  logic          clock, reset, enable, fifo_full;
  logic [N-1:0]  req, src_valid, src_ready, grant;
  logic [N*DW-1:0] src_data;
  logic [SW-1:0] fifo_wr_data_space;
  logic          fifo_wr_en, busy, burst_done;
  logic [DW-1:0] fifo_din;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .BURST_LEN(BL), .SPACE_WIDTH(SW)) dut (
    .clock(clock), .reset(reset), .enable(enable), .req(req),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .grant(grant), .fifo_full(fifo_full), .fifo_wr_data_space(fifo_wr_data_space),
    .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din), .busy(busy), .burst_done(burst_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: who owns the FIFO, how many beats it has written,
  // whether we are in the post-burst gap, and who was served last.
  int  m_owner;
  int  m_beats;
  bit  m_rest;
  bit  m_done;
  int  m_last;
  logic [11:0] seq [N];
  logic [N-1:0] prev_grant;
  int gq[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] beat(input int i);
    return {4'(i), seq[i]};
  endfunction

  task automatic step();
    logic [N-1:0]  e_grant, e_rdy;
    logic          e_wr;
    logic [DW-1:0] e_din;
    for (int i = 0; i < N; i++) src_data[i*DW +: DW] = beat(i);
    #1;
    e_grant = '0;
    e_rdy   = '0;
    e_wr    = 1'b0;
    e_din   = '0;
    if (m_owner >= 0) begin
      e_grant[m_owner] = 1'b1;
      e_rdy            = fifo_full ? '0 : e_grant;
      e_wr             = src_valid[m_owner] && !fifo_full;
      e_din            = beat(m_owner);
    end
    chk("grant", 64'(grant), 64'(e_grant));
    chk("src_ready", 64'(src_ready), 64'(e_rdy));
    chk("fifo_wr_en", 64'(fifo_wr_en), 64'(e_wr));
    chk("fifo_din", 64'(fifo_din), 64'(e_din));
    chk("busy", 64'(busy), 64'((m_owner >= 0) || m_rest));
    chk("burst_done", 64'(burst_done), 64'(m_done));
    if (grant !== prev_grant && grant !== '0) gq.push_back(int'(grant));
    prev_grant = grant;
    @(posedge clock);
    if (reset) begin
      m_owner = -1; m_beats = 0; m_rest = 0; m_done = 0; m_last = N - 1;
    end else begin
      for (int i = 0; i < N; i++) if (src_valid[i] && e_rdy[i]) seq[i]++;
      m_done = 0;
      if (m_owner >= 0) begin
        if (e_wr) begin
          m_beats++;
          if (m_beats == BL) begin
            m_last = m_owner; m_owner = -1; m_rest = 1; m_done = 1;
          end
        end
      end else if (m_rest) begin
        m_rest = 0;
      end else if (enable && req != '0 && int'(fifo_wr_data_space) >= BL) begin
        for (int k = 1; k <= N; k++) begin
          if (m_owner < 0 && req[(m_last + k) % N]) m_owner = (m_last + k) % N;
        end
        m_beats = 0;
      end
    end
    @(negedge clock);
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) step();
  endtask

  task automatic run_to_beat(input int b);
    for (int c = 0; c < 80 && !(m_owner >= 0 && m_beats == b); c++) step();
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; fifo_full = 1'b0; req = '0; src_valid = '0;
    fifo_wr_data_space = '0; src_data = '0; prev_grant = '0;
    for (int i = 0; i < N; i++) seq[i] = 12'(i * 256);
    m_owner = -1; m_beats = 0; m_rest = 0; m_done = 0; m_last = N - 1;
    @(posedge clock);
    @(negedge clock);
    run(3);
    reset = 1'b0;

    // Rotation across all four requesters.
    enable = 1'b1; req = 4'b1111; src_valid = 4'b1111; fifo_wr_data_space = 7'd64;
    gq.delete();
    run(95);
    chk("rot_grant0", 64'(gq[0]), 64'd1);
    chk("rot_grant1", 64'(gq[1]), 64'd2);
    chk("rot_grant2", 64'(gq[2]), 64'd4);
    chk("rot_grant3", 64'(gq[3]), 64'd8);
    chk("rot_grant4", 64'(gq[4]), 64'd1);
    req = '0;
    run(20);

    // Space gate at exactly BURST_LEN.
    req = 4'b0100; fifo_wr_data_space = 7'd15;
    run(5);
    fifo_wr_data_space = 7'd16;
    run(22);
    fifo_wr_data_space = 7'd64;

    // Backpressure at beat 7.
    req = 4'b0001;
    run_to_beat(7);
    req = '0; fifo_full = 1'b1;
    run(5);
    fifo_full = 1'b0;
    run(15);

    // Valid gap on requester 1, req dropped mid-burst.
    req = 4'b0010;
    run_to_beat(5);
    req = '0; src_valid = 4'b1101;
    run(3);
    src_valid = 4'b1111;
    run(15);

    // Enable falls mid-burst.
    req = 4'b1111;
    run_to_beat(4);
    enable = 1'b0;
    run(40);
    enable = 1'b1;
    run(10);

    // Reset mid-burst at beat 9.
    run_to_beat(9);
    reset = 1'b1;
    run(1);
    reset = 1'b0;
    run(25);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      req                = N'($urandom);
      src_valid          = N'($urandom) | N'($urandom);
      fifo_full          = ($urandom_range(0, 9) == 0);
      fifo_wr_data_space = SW'($urandom_range(0, 40));
      enable             = ($urandom_range(0, 9) != 0);
      reset              = ($urandom_range(0, 199) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
